// File: rtl/byte_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : byte_word_assembler
//  Purpose  : Packs a stream of 8-bit bytes into 16-bit words and presents
//             each word on data_out with a single-cycle data_en strobe.
//             A partial word whose second byte is late is dropped, and this
//             is reported with a single-cycle timeout_err strobe.
//  Ports    : clk          - system clock, rising edge
//             rst          - asynchronous reset, active-high
//             byte_in      - incoming byte, qualified by byte_valid
//             byte_valid   - one byte taken per cycle it is high
//             sync_clear   - synchronous resync, drops any partial word
//             data_out     - last assembled word, held between words
//             data_en      - data_out is new this cycle
//             timeout_err  - partial word dropped on timeout
//             word_cnt     - words emitted since reset, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module byte_word_assembler #(
  parameter int LSB_FIRST = 1,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             sync_clear,
  output logic [15:0]      data_out,
  output logic             data_en,
  output logic             timeout_err,
  output logic [CNT_W-1:0] word_cnt
);

  // Timer counts idle cycles spent waiting for the second byte. With
  // TIMEOUT=0 the timer is never compared, so it is kept at one bit.
  localparam int c_TW        = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int c_TMO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(c_TMO_LAST_I);

  typedef enum logic [0:0] {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_hold, w_hold_nxt;
  logic [c_TW-1:0]   r_timer, w_timer_nxt;
  logic [15:0]       r_data_out, w_data_out_nxt;
  logic              r_data_en, w_data_en_nxt;
  logic              r_timeout_err, w_timeout_err_nxt;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic [15:0]       w_word;

  // Byte ordering of the assembled word
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_word = {byte_in, r_hold};
    end else begin : g_msb_first
      assign w_word = {r_hold, byte_in};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FIRST;
      r_hold        <= '0;
      r_timer       <= '0;
      r_data_out    <= '0;
      r_data_en     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_word_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_timer       <= w_timer_nxt;
      r_data_out    <= w_data_out_nxt;
      r_data_en     <= w_data_en_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_hold_nxt        = r_hold;
    w_timer_nxt       = r_timer;
    w_data_out_nxt    = r_data_out;
    w_data_en_nxt     = 1'b0;
    w_timeout_err_nxt = 1'b0;
    w_word_cnt_nxt    = r_word_cnt;

    if (sync_clear) begin
      // Resync wins over any byte arriving in the same cycle
      w_state_nxt = S_FIRST;
      w_timer_nxt = '0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        S_FIRST: begin
          if (byte_valid) begin
            w_hold_nxt  = byte_in;
            w_timer_nxt = '0;
            w_state_nxt = S_SECOND;
          end
        end
        S_SECOND: begin
          if (byte_valid) begin
            // A second byte on the last allowed cycle still completes the word
            w_data_out_nxt = w_word;
            w_data_en_nxt  = 1'b1;
            w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
            w_state_nxt    = S_FIRST;
          end else if ((TIMEOUT != 0) && (r_timer == c_TMO_LAST)) begin
            w_hold_nxt        = '0;
            w_timer_nxt       = '0;
            w_timeout_err_nxt = 1'b1;
            w_state_nxt       = S_FIRST;
          end else if (r_timer != {c_TW{1'b1}}) begin
            // Saturating, so a disabled timeout can idle forever
            w_timer_nxt = r_timer + c_TW'(1);
          end
        end
        default: begin
          w_state_nxt = S_FIRST;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign data_en     = r_data_en;
  assign timeout_err = r_timeout_err;
  assign word_cnt    = r_word_cnt;

endmodule
`default_nettype wire
